// File: rtl/ch_pkt_pkg.sv
// ch_pkt_pkg: shared cluster-head packet types, field widths and advert FSM states
package ch_pkt_pkg;
  localparam int TYPE_W = 4;
  localparam int REP_W = 4;
  localparam int SEQ_W = 8;
  localparam logic [TYPE_W-1:0] CHADV_TYPE = 4'h3;
  localparam logic [15:0] HOPS_NONE = 16'hFFFF;
  localparam logic [15:0] ID_NONE = 16'hFFFF;
  typedef struct packed {
    logic [15:0] CH_ID;
    logic [15:0] CH_Hops;
    logic [15:0] CH_QValue;
  } clusterHeadInformation;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} adv_state_t;
  function automatic logic [15:0] adv_header(input logic [REP_W-1:0] rep, input logic [SEQ_W-1:0] seq);
    return {CHADV_TYPE, rep, seq};
  endfunction
endpackage

// File: rtl/ch_adv_serializer.sv
// ch_adv_serializer: presents header, ID, Hops, Q of one copy under valid/ready hold
module ch_adv_serializer
  import ch_pkt_pkg::*;
#(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  load,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] hdr,
  input  clusterHeadInformation info,
  input  logic                  tx_ready,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  output logic                  copy_done
);
  logic [1:0] word_idx;
  logic [1:0] nxt_idx;
  logic [WORD_WIDTH-1:0] nxt_word;
  logic xfer;
  assign xfer = tx_valid && tx_ready;
  assign copy_done = xfer && word_idx == 2'd3;
  assign nxt_idx = word_idx + 2'd1;
  always_comb
    nxt_word = nxt_idx == 2'd1 ? info.CH_ID : nxt_idx == 2'd2 ? info.CH_Hops : info.CH_QValue;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      word_idx <= 2'd0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
    end else if (abort) begin
      word_idx <= 2'd0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
    end else if (load) begin
      word_idx <= 2'd0;
      tx_data  <= hdr;
      tx_valid <= 1'b1;
      tx_last  <= 1'b0;
    end else if (copy_done) begin
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
    end else if (xfer) begin
      word_idx <= nxt_idx;
      tx_data  <= nxt_word;
      tx_last  <= nxt_idx == 2'd3;
    end
endmodule

// File: rtl/ch_advert_tx.sv
// ch_advert_tx: snapshots CH advert fields and sends ADV_REPEAT gapped copies on the TX bus
module ch_advert_tx
  import ch_pkt_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int ADV_REPEAT = 3,
  parameter int GAP_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en_CHA,
  input  logic                  HB_reset,
  input  logic                  is_CH,
  input  logic [WORD_WIDTH-1:0] my_ID,
  input  logic [WORD_WIDTH-1:0] my_QValue,
  input  logic [WORD_WIDTH-1:0] chosenCH,
  input  logic [WORD_WIDTH-1:0] hopsfromCH,
  input  logic [WORD_WIDTH-1:0] chosenQ,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  adv_state_t state;
  clusterHeadInformation snap, fresh;
  logic [SEQ_W-1:0] seq;
  logic [REP_W-1:0] rep_cnt;
  logic [GW-1:0] gap_cnt;
  logic skip, skip_now, load, copy_done;
  logic [WORD_WIDTH-1:0] hdr;
  always_comb begin
    fresh.CH_ID = is_CH ? my_ID : chosenCH;
    fresh.CH_Hops = is_CH ? 16'h0000 : hopsfromCH == HOPS_NONE ? HOPS_NONE : hopsfromCH + 16'd1;
    fresh.CH_QValue = is_CH ? my_QValue : chosenQ;
  end
  assign skip_now = !is_CH && chosenCH == ID_NONE;
  // the first copy's header is built while rep_cnt is still being cleared
  assign hdr = adv_header(state == S_IDLE ? {REP_W{1'b0}} : rep_cnt, seq);
  assign load = !HB_reset && ((state == S_IDLE && en_CHA && !skip_now) || (state == S_GAP && gap_cnt == '0));
  assign busy = state != S_IDLE;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state   <= S_IDLE;
      snap    <= '0;
      seq     <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      skip    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (HB_reset) begin
        state   <= S_IDLE;
        rep_cnt <= '0;
        gap_cnt <= '0;
      end else
        case (state)
          S_IDLE:
            if (en_CHA) begin
              snap    <= fresh;
              skip    <= skip_now;
              rep_cnt <= '0;
              state   <= skip_now ? S_DONE : S_SEND;
              done    <= skip_now;
            end
          S_SEND:
            if (copy_done) begin
              if (rep_cnt == REP_W'(ADV_REPEAT - 1)) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
                gap_cnt <= GW'(GAP_CYCLES - 1);
                state   <= S_GAP;
              end
            end
          S_GAP:
            if (gap_cnt == '0) state <= S_SEND;
            else gap_cnt <= gap_cnt - 1'b1;
          S_DONE: begin
            state <= S_IDLE;
            if (!skip) seq <= seq + 1'b1;
          end
          default: state <= S_IDLE;
        endcase
    end
  ch_adv_serializer #(.WORD_WIDTH(WORD_WIDTH)) u_ser (
    .clk       (clk),
    .nrst      (nrst),
    .load      (load),
    .abort     (HB_reset),
    .hdr       (hdr),
    .info      (state == S_IDLE ? fresh : snap),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .copy_done (copy_done)
  );
endmodule
